pl_hazard_ctrl: RTL and testbench
=================================

# pl_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32 core (`cpu_pl` family). It tracks in-flight register writers in a shift-register scoreboard of `DEPTH` post-decode slots and produces fetch/decode stall, bubble and flush controls. It also produces registered per-operand forward selects for the instruction entering EX. It generalises the fixed 5-stage load-use/forward logic to arbitrary back-end depth, configurable load latency, an advance-enable input and a stall counter.

## Interface
- `DEPTH`, 3, number of tracked slots after decode (slot 1 = EX, slot `DEPTH` = WB); legal range 2..8.
- `LOAD_AVAIL`, 3, first slot whose output carries load data (2..`DEPTH`).
- `RAW`, 5, register index width.
- `CNT_W`, 32, stall counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  pipeline advance enable; low = hold all state.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_rs1`, `id_rs2`  in  `RAW`  decode source indices.
- `id_rs1_used`, `id_rs2_used`  in  1  operand actually read.
- `id_rd`  in  `RAW`  decode destination.
- `id_wen`  in  1  decode instruction writes `id_rd`.
- `id_is_load`  in  1  decode instruction is a load.
- `ex_redirect`  in  1  taken branch/jal resolved in EX this cycle.
- `stall_f`  out  1  hold PC.
- `stall_d`  out  1  hold IF/ID register.
- `bubble_e`  out  1  load NOP into ID/EX.
- `flush_d`  out  1  load NOP into IF/ID.
- `fwd1`, `fwd2`  out  `$clog2(DEPTH+1)`  operand source for EX instruction: 0 = ID/EX register value, k (2..`DEPTH`) = result of slot k.
- `stall_cnt`  out  `CNT_W`  cycles with `stall_d` asserted and `en` high.

## Operation
- Slot entry: valid, rd, avail (2 for non-load, `LOAD_AVAIL` for load). rd = 0 or `id_wen` = 0 gives an invalid entry.
- Match: slot s valid, rd equals used source index.
- Hazard: a match in current slot s (1..`DEPTH`-1) with s+1 < avail.
- `stall_f` = `stall_d` = `bubble_e` = hazard & `id_valid` & !`ex_redirect`.
- Redirect: `ex_redirect` forces `flush_d` = 1 and `bubble_e` = 1, with stalls 0. Redirect overrides hazard.
- Advance (`en` high, each edge): slot k+1 ← slot k; slot `DEPTH` retires; slot 1 ← decode entry if `id_valid` & !`bubble_e`, else invalid.
- Forward selects, registered on the same edge: for each operand, k = (youngest matching current slot s in 1..`DEPTH`-1) + 1; fwd = k, or 0 if no match, if bubbling, or if the operand is unused. The youngest match wins when several slots share rd.
- Register file read port is write-first, so a producer retiring from slot `DEPTH` on the same edge needs no forward.
- `en` low: slots, fwd and counter hold; combinational outputs still reflect current state.

## Timing
- Reset: all slots invalid; `fwd1` = `fwd2` = 0; `stall_cnt` = 0; `stall_f`/`stall_d`/`bubble_e`/`flush_d` = 0.
- Hazard to stall: zero-cycle (combinational from decode inputs and slot state).
- Load-use with defaults: exactly 1 stall cycle. General stall length = avail − 2 cycles with forwarding.
- fwd valid in the cycle the consumer occupies EX (1 edge after decode).
- Reset mid-operation discards all in-flight entries; the first post-reset decode sees no hazard.
- `stall_cnt` saturates at all-ones.

## Configuration
- `PL_HAZARD_FWD_EN` defined: behaviour as above.
- Undefined: no forwarding. Avail = `DEPTH` + 1 for every entry, so any match in slots 1..`DEPTH`-1 stalls. `fwd1`/`fwd2` are tied to 0.

## Structure
- `cpu_pl_pkg`: slot-entry struct (valid, rd, avail), fwd code width function, constants `FWD_REG` = 0 and `AVAIL_ALU` = 2.
- One sub-module, `pl_slot_match`: combinational per-slot rd compare returning match and hazard bits. It is instantiated `DEPTH` × 2 times.

## Test plan
- ALU chain: `addi x5`, then `add x6,x5,x5` → no stall; `fwd1` = `fwd2` = 2 when `add` is in EX.
- Load-use (`DEPTH` = 3, `LOAD_AVAIL` = 3): `lw x7`, then `add x8,x7,x0` → `stall_f`/`stall_d`/`bubble_e` high for 1 cycle; then `fwd1` = 3, `fwd2` = 0; `stall_cnt` = 1.
- Writer to x0: `addi x0`, then `add x1,x0,x0` → no stall, fwd = 0.
- Redirect during hazard: `ex_redirect` = 1 in the same cycle as a load-use match → `flush_d` = 1, `bubble_e` = 1, `stall_f` = 0.
- Two writers to x9 in slots 1 and 2, consumer reads x9 → fwd = 2 (youngest wins).
- `DEPTH` = 5, `LOAD_AVAIL` = 5, macro undefined: ALU writer then dependent consumer → 4 stall cycles; assert `rst` during the 2nd stall → all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pl_pkg
//  Description : Shared types and constants for the cpu_pl hazard/forwarding
//                logic: scoreboard slot entry, forward-select codes and the
//                forward-code width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pl_pkg;

    // Widest register index a slot can hold. Instantiations use RAW <= 8.
    localparam int RAW_MAX = 8;
    // Holds avail values up to DEPTH+1 = 9.
    localparam int AVAIL_W = 4;

    // Forward code 0 selects the ID/EX register value.
    localparam int FWD_REG   = 0;
    // First slot whose output carries an ALU result.
    localparam int AVAIL_ALU = 2;

    // One in-flight writer. avail is the first slot whose output carries
    // the result.
    typedef struct packed {
        logic               valid;
        logic [RAW_MAX-1:0] rd;
        logic [AVAIL_W-1:0] avail;
    } slot_t;

    // Forward select codes run 0..DEPTH.
    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pl_slot_match.sv
`default_nettype none
// ============================================================================
//  Module      : pl_slot_match
//  Description : Compares one scoreboard slot against one decode source
//                operand. match is raised when the slot sits inside the
//                forwarding window (SLOT < DEPTH) and its writer targets the
//                used source register. hazard is raised when that writer's
//                result is not available by the time the consumer reaches EX.
//  Revision    : 1.0 - initial release
//
//  Ports
//    src       in  RAW      decode source register index
//    src_used  in  1        source operand is actually read
//    entry     in  slot_t   scoreboard slot contents
//    match     out 1        slot writes src (inside the window)
//    hazard    out 1        match whose result is still too late
// ============================================================================
module pl_slot_match
    import cpu_pl_pkg::*;
#(
    parameter int SLOT  = 1,
    parameter int DEPTH = 3,
    parameter int RAW   = 5
) (
    input  logic [RAW-1:0] src,
    input  logic           src_used,
    input  slot_t          entry,
    output logic           match,
    output logic           hazard
);

    // The last slot retires into the write-first register file on the same
    // edge the consumer reads it, so it never needs forwarding or stalling.
    localparam logic c_in_window = (SLOT < DEPTH);
    // The consumer reaches EX one edge later, when this writer is in SLOT+1.
    localparam logic [AVAIL_W-1:0] c_next_slot = AVAIL_W'(SLOT + 1);

    assign match  = c_in_window & src_used & entry.valid
                  & (entry.rd == RAW_MAX'(src));
    assign hazard = match & (c_next_slot < entry.avail);

endmodule
`default_nettype wire

// File: rtl/pl_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pl_hazard_ctrl
//  Description : Hazard and forwarding controller for the cpu_pl pipeline.
//                A DEPTH-slot shift-register scoreboard tracks post-decode
//                register writers. Produces combinational stall / bubble /
//                flush controls and registered per-operand forward selects
//                for the instruction entering EX.
//  Revision    : 1.0 - initial release
//
//  Build option
//    PL_HAZARD_FWD_EN  defined   : forwarding; ALU results usable from
//                                  slot 2, loads from slot LOAD_AVAIL.
//                      undefined : no forwarding; any in-window match stalls
//                                  and fwd1/fwd2 are tied to 0.
//
//  Ports
//    clk          in  1        clock
//    rst          in  1        asynchronous active-high reset
//    en           in  1        pipeline advance enable (low = hold state)
//    id_valid     in  1        decode slot holds a real instruction
//    id_rs1/2     in  RAW      decode source indices
//    id_rs1/2_used in 1        operand is actually read
//    id_rd        in  RAW      decode destination
//    id_wen       in  1        decode instruction writes id_rd
//    id_is_load   in  1        decode instruction is a load
//    ex_redirect  in  1        taken branch/jump resolved in EX
//    stall_f      out 1        hold PC
//    stall_d      out 1        hold IF/ID
//    bubble_e     out 1        load NOP into ID/EX
//    flush_d      out 1        load NOP into IF/ID
//    fwd1/2       out clog2(DEPTH+1)  EX operand source (0 = ID/EX, k = slot k)
//    stall_cnt    out CNT_W    saturating count of enabled stall cycles
// ============================================================================
module pl_hazard_ctrl
    import cpu_pl_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 3,
    parameter int RAW        = 5,
    parameter int CNT_W      = 32,
    localparam int FW        = fwd_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             id_valid,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RAW-1:0]   id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             flush_d,
    output logic [FW-1:0]    fwd1,
    output logic [FW-1:0]    fwd2,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef PL_HAZARD_FWD_EN
    localparam logic [AVAIL_W-1:0] c_avail_alu  = AVAIL_W'(AVAIL_ALU);
    localparam logic [AVAIL_W-1:0] c_avail_load = AVAIL_W'(LOAD_AVAIL);
`else
    // Without forwarding a result is only visible through the register file,
    // i.e. once the writer has left the last slot.
    localparam logic [AVAIL_W-1:0] c_avail_alu  = AVAIL_W'(DEPTH + 1);
    localparam logic [AVAIL_W-1:0] c_avail_load = AVAIL_W'(DEPTH + 1);
`endif

    // Slot 1 = EX ... slot DEPTH = WB.
    slot_t [DEPTH:1]  r_slot;
    slot_t            w_entry;
    logic  [DEPTH:1]  w_m1, w_h1, w_m2, w_h2;
    logic             w_hazard;
    logic             w_stall;
    logic [CNT_W-1:0] r_cnt;

    // Writes to x0 are discarded, so they never create a dependency.
    always_comb begin
        w_entry       = '0;
        w_entry.valid = id_wen & (id_rd != '0);
        w_entry.rd    = RAW_MAX'(id_rd);
        w_entry.avail = id_is_load ? c_avail_load : c_avail_alu;
    end

    for (genvar s = 1; s <= DEPTH; s++) begin : g_slot
        pl_slot_match #(
            .SLOT  (s),
            .DEPTH (DEPTH),
            .RAW   (RAW)
        ) u_match_rs1 (
            .src      (id_rs1),
            .src_used (id_rs1_used),
            .entry    (r_slot[s]),
            .match    (w_m1[s]),
            .hazard   (w_h1[s])
        );

        pl_slot_match #(
            .SLOT  (s),
            .DEPTH (DEPTH),
            .RAW   (RAW)
        ) u_match_rs2 (
            .src      (id_rs2),
            .src_used (id_rs2_used),
            .entry    (r_slot[s]),
            .match    (w_m2[s]),
            .hazard   (w_h2[s])
        );
    end

`ifdef PL_HAZARD_FWD_EN
    assign w_hazard = (|w_h1) | (|w_h2);
`else
    // Every avail is DEPTH+1, so any in-window match is already a hazard.
    assign w_hazard = (|w_h1) | (|w_h2) | (|w_m1) | (|w_m2);
`endif

    // A redirect squashes the decode instruction, so its hazard is moot.
    assign w_stall  = w_hazard & id_valid & ~ex_redirect;
    assign stall_f  = w_stall;
    assign stall_d  = w_stall;
    assign bubble_e = w_stall | ex_redirect;
    assign flush_d  = ex_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (en) begin
            r_slot[1] <= (id_valid & ~bubble_e) ? w_entry : '0;
            for (int s = 2; s <= DEPTH; s++) begin
                r_slot[s] <= r_slot[s-1];
            end
        end
    end

`ifdef PL_HAZARD_FWD_EN
    logic [FW-1:0] w_fwd1, w_fwd2;
    logic [FW-1:0] r_fwd1, r_fwd2;

    // Scan oldest to youngest so the youngest matching writer wins. A match
    // in slot s is read from slot s+1 once the consumer is in EX.
    always_comb begin
        w_fwd1 = FW'(FWD_REG);
        w_fwd2 = FW'(FWD_REG);
        for (int s = DEPTH; s >= 1; s--) begin
            if (w_m1[s]) w_fwd1 = FW'(s + 1);
            if (w_m2[s]) w_fwd2 = FW'(s + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd1 <= FW'(FWD_REG);
            r_fwd2 <= FW'(FWD_REG);
        end else if (en) begin
            r_fwd1 <= bubble_e ? FW'(FWD_REG) : w_fwd1;
            r_fwd2 <= bubble_e ? FW'(FWD_REG) : w_fwd2;
        end
    end

    assign fwd1 = r_fwd1;
    assign fwd2 = r_fwd2;
`else
    assign fwd1 = FW'(FWD_REG);
    assign fwd2 = FW'(FWD_REG);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en && stall_d && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pl_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pl_hazard_ctrl
//  Description : Self-checking bench for pl_hazard_ctrl. A DEPTH=3 instance
//                runs a directed vector table; a DEPTH=5 / LOAD_AVAIL=5
//                instance with a 2-bit stall counter runs the long-stall,
//                counter-saturation and mid-stall reset sequences.
//                Expected values follow the PL_HAZARD_FWD_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_hazard_ctrl;

`ifdef PL_HAZARD_FWD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_rs1_used, id_rs2_used, id_wen, id_is_load, ex_redirect;

    logic        d3_stall_f, d3_stall_d, d3_bubble_e, d3_flush_d;
    logic [1:0]  d3_fwd1, d3_fwd2;
    logic [31:0] d3_cnt;
    logic        d5_stall_f, d5_stall_d, d5_bubble_e, d5_flush_d;
    logic [2:0]  d5_fwd1, d5_fwd2;
    logic [1:0]  d5_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pl_hazard_ctrl #(.DEPTH(3), .LOAD_AVAIL(3)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect),
        .stall_f(d3_stall_f), .stall_d(d3_stall_d), .bubble_e(d3_bubble_e),
        .flush_d(d3_flush_d), .fwd1(d3_fwd1), .fwd2(d3_fwd2), .stall_cnt(d3_cnt)
    );

    pl_hazard_ctrl #(.DEPTH(5), .LOAD_AVAIL(5), .CNT_W(2)) u_d5 (
        .clk(clk), .rst(rst), .en(en), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect),
        .stall_f(d5_stall_f), .stall_d(d5_stall_d), .bubble_e(d5_bubble_e),
        .flush_d(d5_flush_d), .fwd1(d5_fwd1), .fwd2(d5_fwd2), .stall_cnt(d5_cnt)
    );

    typedef struct {
        int vld, rs1, u1, rs2, u2, rd, wen, ld, redir, en;
        int e_stall, e_flush, e_fwd1, e_fwd2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int vld, input int rs1, input int u1,
                                input int rs2, input int u2, input int rd,
                                input int wen, input int ld, input int redir,
                                input int ena, input int e_stall, input int e_flush,
                                input int e_fwd1, input int e_fwd2);
        vec_t v;
        v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.wen = wen; v.ld = ld; v.redir = redir; v.en = ena;
        v.e_stall = e_stall; v.e_flush = e_flush;
        v.e_fwd1 = e_fwd1; v.e_fwd2 = e_fwd2;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int vld, input int rs1, input int u1,
                         input int rs2, input int u2, input int rd,
                         input int wen, input int ld, input int redir, input int ena);
        id_valid    = (vld != 0);
        id_rs1      = 5'(rs1);
        id_rs1_used = (u1 != 0);
        id_rs2      = 5'(rs2);
        id_rs2_used = (u2 != 0);
        id_rd       = 5'(rd);
        id_wen      = (wen != 0);
        id_is_load  = (ld != 0);
        ex_redirect = (redir != 0);
        en          = (ena != 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int nst;
        rst = 1'b1;
        idle();

        // Reset state on both instances
        @(negedge clk);
        #1;
        chk("rst.d3.stall_f", int'(d3_stall_f), 0);
        chk("rst.d3.stall_d", int'(d3_stall_d), 0);
        chk("rst.d3.bubble_e", int'(d3_bubble_e), 0);
        chk("rst.d3.flush_d", int'(d3_flush_d), 0);
        chk("rst.d3.fwd1", int'(d3_fwd1), 0);
        chk("rst.d3.fwd2", int'(d3_fwd2), 0);
        chk("rst.d3.cnt", int'(d3_cnt), 0);
        chk("rst.d5.stall_f", int'(d5_stall_f), 0);
        chk("rst.d5.fwd1", int'(d5_fwd1), 0);
        chk("rst.d5.cnt", int'(d5_cnt), 0);
        rst = 1'b0;

        //        vld rs1 u1 rs2 u2 rd wen ld rdr en  stall flush fwd1 fwd2
        if (c_fwd) begin
            vecs.push_back(mk(1,  0, 1,  0, 0,  5, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x5
            vecs.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 1,  0, 0, 0, 0)); // add x6,x5,x5
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 2, 2)); // add in EX
            vecs.push_back(mk(1,  0, 1,  0, 0,  7, 1, 1, 0, 1,  0, 0, 0, 0)); // lw x7
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 1,  1, 0, 0, 0)); // add x8,x7,x0 load-use
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 1,  0, 0, 0, 0)); // released
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 3, 0)); // load data fwd
            vecs.push_back(mk(1,  0, 1,  0, 0,  0, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x0
            vecs.push_back(mk(1,  0, 1,  0, 1,  1, 1, 0, 0, 1,  0, 0, 0, 0)); // add x1,x0,x0
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(1,  0, 1,  0, 0,  9, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x9
            vecs.push_back(mk(1,  0, 1,  0, 0,  9, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x9
            vecs.push_back(mk(1,  9, 1,  9, 1, 10, 1, 0, 0, 1,  0, 0, 0, 0)); // add x10,x9,x9
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 2, 2)); // youngest wins
            vecs.push_back(mk(1,  0, 1,  0, 0, 11, 1, 1, 0, 1,  0, 0, 0, 0)); // lw x11
            vecs.push_back(mk(1, 11, 1,  0, 0, 12, 1, 0, 1, 1,  0, 1, 0, 0)); // redirect over hazard
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(1,  0, 1,  0, 0, 13, 1, 1, 0, 1,  0, 0, 0, 0)); // lw x13
            vecs.push_back(mk(1, 13, 1, 13, 0, 14, 1, 0, 0, 0,  1, 0, 0, 0)); // en low, stall shown
            vecs.push_back(mk(1, 13, 1, 13, 0, 14, 1, 0, 0, 1,  1, 0, 0, 0));
            vecs.push_back(mk(1, 13, 1, 13, 0, 14, 1, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(1, 14, 0, 13, 1,  0, 0, 0, 0, 1,  0, 0, 3, 0)); // rs2 from last slot
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        end else begin
            vecs.push_back(mk(1,  0, 1,  0, 0,  5, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x5
            vecs.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 1,  1, 0, 0, 0)); // add x6 (slot1)
            vecs.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 1,  1, 0, 0, 0)); // (slot2)
            vecs.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 1,  0, 0, 0, 0)); // writer in WB
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(1,  0, 1,  0, 0,  0, 1, 0, 0, 1,  0, 0, 0, 0)); // addi x0
            vecs.push_back(mk(1,  0, 1,  0, 1,  1, 1, 0, 0, 1,  0, 0, 0, 0)); // add x1,x0,x0
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(1,  0, 1,  0, 0,  7, 1, 1, 0, 1,  0, 0, 0, 0)); // lw x7
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 1, 1,  0, 1, 0, 0)); // redirect over hazard
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 0,  1, 0, 0, 0)); // en low
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 1,  1, 0, 0, 0));
            vecs.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 1,  0, 0, 0, 0));
            vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0));
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
                  vecs[i].rd, vecs[i].wen, vecs[i].ld, vecs[i].redir, vecs[i].en);
            #1;
            chk($sformatf("v%0d.stall_f", i), int'(d3_stall_f), vecs[i].e_stall);
            chk($sformatf("v%0d.stall_d", i), int'(d3_stall_d), vecs[i].e_stall);
            chk($sformatf("v%0d.bubble_e", i), int'(d3_bubble_e),
                (vecs[i].e_stall != 0 || vecs[i].e_flush != 0) ? 1 : 0);
            chk($sformatf("v%0d.flush_d", i), int'(d3_flush_d), vecs[i].e_flush);
            chk($sformatf("v%0d.fwd1", i), int'(d3_fwd1), vecs[i].e_fwd1);
            chk($sformatf("v%0d.fwd2", i), int'(d3_fwd2), vecs[i].e_fwd2);
        end

        @(negedge clk);
        idle();
        #1;
        chk("d3.stall_cnt", int'(d3_cnt), c_fwd ? 2 : 3);

        // DEPTH=5 long stall: load writer with forwarding, ALU writer without
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        nst = c_fwd ? 3 : 4;

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 20, 1, int'(c_fwd), 0, 1);
        #1 chk("d5.writer.stall", int'(d5_stall_f), 0);
        for (int i = 0; i < nst; i++) begin
            @(negedge clk);
            drive(1, 20, 1, 0, 0, 21, 1, 0, 0, 1);
            #1;
            chk($sformatf("d5.stall%0d.stall_f", i), int'(d5_stall_f), 1);
            chk($sformatf("d5.stall%0d.bubble_e", i), int'(d5_bubble_e), 1);
        end
        @(negedge clk);
        drive(1, 20, 1, 0, 0, 21, 1, 0, 0, 1);
        #1 chk("d5.release.stall_f", int'(d5_stall_f), 0);
        @(negedge clk);
        idle();
        #1;
        chk("d5.fwd1", int'(d5_fwd1), c_fwd ? 5 : 0);
        chk("d5.fwd2", int'(d5_fwd2), 0);
        chk("d5.cnt", int'(d5_cnt), 3);

        // Second pass: reset during the 2nd stall cycle
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 20, 1, int'(c_fwd), 0, 1);
        #1 chk("d5r.writer.stall", int'(d5_stall_f), 0);
        @(negedge clk);
        drive(1, 20, 1, 0, 0, 21, 1, 0, 0, 1);
        #1 chk("d5r.stall1", int'(d5_stall_f), 1);
        @(negedge clk);
        #1;
        chk("d5r.stall2", int'(d5_stall_d), 1);
        chk("d5r.cnt_sat", int'(d5_cnt), 3);
        #1 rst = 1'b1;
        #1;
        chk("d5r.rst.stall_f", int'(d5_stall_f), 0);
        chk("d5r.rst.stall_d", int'(d5_stall_d), 0);
        chk("d5r.rst.bubble_e", int'(d5_bubble_e), 0);
        chk("d5r.rst.flush_d", int'(d5_flush_d), 0);
        chk("d5r.rst.fwd1", int'(d5_fwd1), 0);
        chk("d5r.rst.fwd2", int'(d5_fwd2), 0);
        chk("d5r.rst.cnt", int'(d5_cnt), 0);
        rst = 1'b0;
        #1 chk("d5r.post.stall_f", int'(d5_stall_f), 0);
        @(negedge clk);
        idle();
        #1;
        chk("d5r.post.fwd1", int'(d5_fwd1), 0);
        chk("d5r.post.cnt", int'(d5_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
